sw_debounce: RTL and testbench

//  Conditions the four raw slide-switch pins before they reach
//  sw_pio_external_connection_export of the HPS/Qsys system.
//  Per bit: 2-FF synchroniser, then debounce counter.

---
 rtl/sw_debounce.sv | 82 ++++++++
 tb/tb_sw_debounce.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - slide-switch synchroniser, debouncer, edge strobes and change counter
module sw_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    input  logic             clr_count,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             change_valid,
    output logic [15:0]      change_count
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] differ;
    logic [WIDTH-1:0] accept;
    logic [CNT_W-1:0] cnt [WIDTH];

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw_raw;
            s2 <= s1;
        end
    end

    // A bit is pending whenever the synchronised input disagrees with the accepted level.
    always_comb begin
        differ = s2 ^ sw_stable;
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = differ[i] && (cnt[i] == LAST);
        end
    end

    // Any return to the accepted level clears the count, so a glitch restarts the window.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!differ[i] || accept[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sw_stable    <= '0;
            sw_rise      <= '0;
            sw_fall      <= '0;
            change_valid <= 1'b0;
            change_count <= '0;
        end else begin
            sw_stable    <= sw_stable ^ accept;
            sw_rise      <= accept & s2;
            sw_fall      <= accept & ~s2;
            change_valid <= |accept;
            if (clr_count) begin
                change_count <= '0;
            end else if (|accept) begin
                change_count <= change_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sw_debounce.sv
// tb/tb_sw_debounce.sv - directed self-checking bench for sw_debounce
module tb_sw_debounce;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic [3:0]  sw_raw = 4'h0;
    logic        clr_count = 1'b0;
    logic [3:0]  sw_stable;
    logic [3:0]  sw_rise;
    logic [3:0]  sw_fall;
    logic        change_valid;
    logic [15:0] change_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] base;

    sw_debounce #(
        .WIDTH(4),
        .DEBOUNCE_CYCLES(8),
        .CNT_W(4)
    ) dut (
        .clk_clk(clk_clk),
        .reset_reset_n(reset_reset_n),
        .sw_raw(sw_raw),
        .clr_count(clr_count),
        .sw_stable(sw_stable),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall),
        .change_valid(change_valid),
        .change_count(change_count)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    task automatic test_reset;
        reset_reset_n = 1'b0;
        sw_raw = 4'hF;
        tick(3);
        n_checks++; if (sw_stable !== 4'h0) begin n_fail++; $display("FAIL reset_stable got %h want 0", sw_stable); end
        n_checks++; if (sw_rise !== 4'h0 || sw_fall !== 4'h0) begin n_fail++; $display("FAIL reset_strobes got %h/%h want 0/0", sw_rise, sw_fall); end
        n_checks++; if (change_valid !== 1'b0 || change_count !== 16'h0) begin n_fail++; $display("FAIL reset_count got %b/%h want 0/0", change_valid, change_count); end
        reset_reset_n = 1'b1;
        tick(9);
        n_checks++; if (sw_stable !== 4'h0) begin n_fail++; $display("FAIL powerup_early got %h want 0", sw_stable); end
        tick(1);
        n_checks++; if (sw_stable !== 4'hF) begin n_fail++; $display("FAIL powerup_stable got %h want f", sw_stable); end
        n_checks++; if (sw_rise !== 4'hF || change_valid !== 1'b1) begin n_fail++; $display("FAIL powerup_rise got %h/%b want f/1", sw_rise, change_valid); end
        n_checks++; if (change_count !== 16'd1) begin n_fail++; $display("FAIL powerup_count got %0d want 1", change_count); end
        tick(1);
        n_checks++; if (sw_rise !== 4'h0 || change_valid !== 1'b0) begin n_fail++; $display("FAIL powerup_pulse got %h/%b want 0/0", sw_rise, change_valid); end
    endtask

    task automatic test_clean_edge;
        sw_raw = 4'h0;
        tick(12);
        n_checks++; if (sw_stable !== 4'h0 || change_count !== 16'd2) begin n_fail++; $display("FAIL all_low got %h/%0d want 0/2", sw_stable, change_count); end
        base = change_count;
        sw_raw = 4'h1;
        tick(9);
        n_checks++; if (sw_stable !== 4'h0) begin n_fail++; $display("FAIL clean_early got %h want 0", sw_stable); end
        tick(1);
        n_checks++; if (sw_stable !== 4'h1 || sw_rise !== 4'h1 || sw_fall !== 4'h0) begin n_fail++; $display("FAIL clean_rise got %h/%h/%h want 1/1/0", sw_stable, sw_rise, sw_fall); end
        tick(1);
        n_checks++; if (sw_rise !== 4'h0) begin n_fail++; $display("FAIL clean_rise_pulse got %h want 0", sw_rise); end
        sw_raw = 4'h0;
        tick(9);
        n_checks++; if (sw_stable !== 4'h1 || sw_fall !== 4'h0) begin n_fail++; $display("FAIL clean_fall_early got %h/%h want 1/0", sw_stable, sw_fall); end
        tick(1);
        n_checks++; if (sw_stable !== 4'h0 || sw_fall !== 4'h1 || sw_rise !== 4'h0) begin n_fail++; $display("FAIL clean_fall got %h/%h/%h want 0/1/0", sw_stable, sw_fall, sw_rise); end
        tick(1);
        n_checks++; if (change_count !== base + 16'd2) begin n_fail++; $display("FAIL clean_count got %0d want %0d", change_count, base + 16'd2); end
    endtask

    task automatic test_bounce;
        base = change_count;
        sw_raw = 4'h2; tick(3);
        sw_raw = 4'h0; tick(3);
        sw_raw = 4'h2;
        tick(9);
        n_checks++; if (sw_stable !== 4'h0 || change_count !== base) begin n_fail++; $display("FAIL bounce_early got %h/%0d want 0/%0d", sw_stable, change_count, base); end
        tick(1);
        n_checks++; if (sw_stable !== 4'h2 || sw_rise !== 4'h2) begin n_fail++; $display("FAIL bounce_accept got %h/%h want 2/2", sw_stable, sw_rise); end
        tick(1);
        n_checks++; if (change_count !== base + 16'd1 || sw_rise !== 4'h0) begin n_fail++; $display("FAIL bounce_count got %0d/%h want %0d/0", change_count, sw_rise, base + 16'd1); end
    endtask

    task automatic test_glitch;
        logic [3:0] seen;
        logic       cv_seen;
        seen = 4'h0;
        cv_seen = 1'b0;
        base = change_count;
        sw_raw = 4'h6;
        for (int k = 0; k < 20; k++) begin
            if (k == 7) sw_raw = 4'h2;
            tick(1);
            seen = seen | sw_rise | sw_fall;
            cv_seen = cv_seen | change_valid;
        end
        n_checks++; if (sw_stable !== 4'h2) begin n_fail++; $display("FAIL glitch_stable got %h want 2", sw_stable); end
        n_checks++; if (seen !== 4'h0 || cv_seen !== 1'b0) begin n_fail++; $display("FAIL glitch_strobes got %h/%b want 0/0", seen, cv_seen); end
        n_checks++; if (change_count !== base) begin n_fail++; $display("FAIL glitch_count got %0d want %0d", change_count, base); end
    endtask

    task automatic test_simultaneous;
        base = change_count;
        sw_raw = 4'hB;
        tick(9);
        n_checks++; if (sw_stable !== 4'h2) begin n_fail++; $display("FAIL simul_early got %h want 2", sw_stable); end
        tick(1);
        n_checks++; if (sw_stable !== 4'hB || sw_rise !== 4'h9 || change_valid !== 1'b1) begin n_fail++; $display("FAIL simul_accept got %h/%h/%b want b/9/1", sw_stable, sw_rise, change_valid); end
        tick(1);
        n_checks++; if (change_valid !== 1'b0) begin n_fail++; $display("FAIL simul_pulse got %b want 0", change_valid); end
        n_checks++; if (change_count !== base + 16'd1) begin n_fail++; $display("FAIL simul_count got %0d want %0d", change_count, base + 16'd1); end
    endtask

    task automatic test_wrap_clear;
        force dut.change_count = 16'hFFFF;
        #1;
        release dut.change_count;
        tick(1);
        sw_raw = 4'h3;
        tick(10);
        n_checks++; if (sw_fall !== 4'h8 || change_count !== 16'h0000) begin n_fail++; $display("FAIL wrap got %h/%h want 8/0000", sw_fall, change_count); end
        sw_raw = 4'h7;
        tick(11);
        n_checks++; if (sw_stable !== 4'h7 || change_count !== 16'd1) begin n_fail++; $display("FAIL after_wrap got %h/%0d want 7/1", sw_stable, change_count); end
        sw_raw = 4'h3;
        tick(9);
        clr_count = 1'b1;
        tick(1);
        clr_count = 1'b0;
        n_checks++; if (sw_fall !== 4'h4 || change_valid !== 1'b1) begin n_fail++; $display("FAIL clr_strobe got %h/%b want 4/1", sw_fall, change_valid); end
        n_checks++; if (change_count !== 16'd0) begin n_fail++; $display("FAIL clr_count got %0d want 0", change_count); end
        tick(2);
        sw_raw = 4'hB;
        tick(7);
        reset_reset_n = 1'b0;
        #1;
        n_checks++; if (sw_stable !== 4'h0 || change_count !== 16'd0 || change_valid !== 1'b0) begin n_fail++; $display("FAIL midreset got %h/%0d/%b want 0/0/0", sw_stable, change_count, change_valid); end
        tick(2);
        reset_reset_n = 1'b1;
        tick(9);
        n_checks++; if (sw_stable !== 4'h0) begin n_fail++; $display("FAIL midreset_window got %h want 0", sw_stable); end
        tick(1);
        n_checks++; if (sw_stable !== 4'hB || sw_rise !== 4'hB || change_count !== 16'd1) begin n_fail++; $display("FAIL midreset_accept got %h/%h/%0d want b/b/1", sw_stable, sw_rise, change_count); end
    endtask

    initial begin
        tick(1);
        test_reset;
        test_clean_edge;
        test_bounce;
        test_glitch;
        test_simultaneous;
        test_wrap_clear;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
